// File: rtl/out_ctl.sv
// Output-side controller: converts each finished accumulator result (round, ReLU, saturate),
// buffers it in a 2-entry FIFO and streams it out over a valid/ready handshake.
module out_ctl #(
  parameter int ACCW = 32,
  parameter int OW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      sample,
  input  logic [4:0]      shift,
  input  logic            relu,
  input  logic            s_init,
  input  logic            k_fin,
  input  logic [ACCW-1:0] acc,
  output logic            out_busy,
  output logic            outrf,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [OW-1:0]   m_data,
  output logic            m_last,
  output logic            ovf
);

  // Saturation limits held at the widened conversion width so the compare sees the full value.
  localparam logic signed [ACCW:0] SAT_MAX = {{(ACCW-OW+2){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACCW:0] SAT_MIN = {{(ACCW-OW+2){1'b1}}, {(OW-1){1'b0}}};
  localparam logic signed [ACCW:0] ONE     = {{ACCW{1'b0}}, 1'b1};
  localparam logic [OW-1:0]        OUT_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0]        OUT_MIN = {1'b1, {(OW-1){1'b0}}};

  logic signed [ACCW:0] ext;
  logic signed [ACCW:0] rnd;
  logic signed [ACCW:0] sum;
  logic signed [ACCW:0] r;
  logic [OW-1:0]        conv;

  logic [OW-1:0] mem [2];
  logic          wptr;
  logic          rptr;
  logic [1:0]    count;
  logic [4:0]    oc;
  logic          push;
  logic          pop;

  // One guard bit keeps the rounding add from wrapping at the positive extreme.
  always_comb begin
    ext  = {acc[ACCW-1], acc};
    rnd  = '0;
    if (shift != 5'd0) rnd = ONE << (shift - 5'd1);
    sum  = ext + rnd;
    r    = (shift == 5'd0) ? ext : (sum >>> shift);
    if (relu && (r < 0)) r = '0;
    if (r > SAT_MAX)      conv = OUT_MAX;
    else if (r < SAT_MIN) conv = OUT_MIN;
    else                  conv = r[OW-1:0];
  end

  assign m_valid  = (count != 2'd0);
  assign outrf    = (count == 2'd0);
  assign out_busy = (count != 2'd0);
  assign m_data   = mem[rptr];
  assign m_last   = m_valid & (oc == sample);

  assign pop  = m_valid & m_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign push = k_fin & ((count != 2'd2) | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= conv;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oc  <= 5'd0;
      ovf <= 1'b0;
    end else begin
      if (s_init)           ovf <= 1'b0;
      else if (k_fin && !push) ovf <= 1'b1;
      if (s_init)           oc <= 5'd0;
      else if (pop)         oc <= (oc == sample) ? 5'd0 : oc + 5'd1;
    end
  end

endmodule

// File: tb/tb_out_ctl.sv
// Bench for out_ctl: directed scenarios plus random traffic, checked every cycle against a
// queue-based reference of the output stream.
module tb_out_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  sample;
  logic [4:0]  shift;
  logic        relu;
  logic        s_init;
  logic        k_fin;
  logic [31:0] acc;
  logic        out_busy;
  logic        outrf;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  logic [15:0] q[$];
  int          npop;
  bit          ovf_m;

  out_ctl #(.ACCW(32), .OW(16)) dut (
    .clk(clk), .rst(rst), .sample(sample), .shift(shift), .relu(relu),
    .s_init(s_init), .k_fin(k_fin), .acc(acc), .out_busy(out_busy), .outrf(outrf),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_conv(input logic [31:0] a, input int sh, input bit rl);
    longint v;
    v = longint'($signed(a));
    if (sh != 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
    if (rl && v < 0) v = 0;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  // One clock cycle: drive inputs, compare outputs with the reference, then advance the reference.
  task automatic cyc(input bit kf, input logic [31:0] a, input bit rdy, input bit si = 1'b0);
    bit vld, pp;
    k_fin   = kf;
    acc     = a;
    m_ready = rdy;
    s_init  = si;
    #1;
    vld = (q.size() != 0);
    chk("m_valid",  {31'b0, m_valid},  {31'b0, vld});
    chk("outrf",    {31'b0, outrf},    {31'b0, !vld});
    chk("out_busy", {31'b0, out_busy}, {31'b0, vld});
    chk("ovf",      {31'b0, ovf},      {31'b0, ovf_m});
    chk("m_last",   {31'b0, m_last},
        {31'b0, vld && ((npop % (int'(sample) + 1)) == int'(sample))});
    if (vld) chk("m_data", {16'b0, m_data}, {16'b0, q[0]});
    pp = vld && rdy;
    if (pp) begin
      void'(q.pop_front());
      npop++;
    end
    if (kf) begin
      if (q.size() < 2) q.push_back(ref_conv(a, int'(shift), relu));
      else ovf_m = 1'b1;
    end
    if (si) begin
      npop  = 0;
      ovf_m = 1'b0;
    end
    @(posedge clk);
    #1;
    k_fin  = 1'b0;
    s_init = 1'b0;
  endtask

  logic [31:0] rvals [5] = '{32'd24, 32'hFFFF_FFE8, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFE8};
  logic [15:0] rexp  [5] = '{16'h0002, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
  bit          lexp  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; sample = 5'd3; shift = 5'd0; relu = 1'b0;
    s_init = 1'b0; k_fin = 1'b0; acc = '0; m_ready = 1'b0;
    npop = 0; ovf_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid",  {31'b0, m_valid},  32'd0);
    chk("rst_outrf",    {31'b0, outrf},    32'd1);
    chk("rst_out_busy", {31'b0, out_busy}, 32'd0);
    chk("rst_m_last",   {31'b0, m_last},   32'd0);
    chk("rst_m_data",   {16'b0, m_data},   32'd0);
    chk("rst_ovf",      {31'b0, ovf},      32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic stream: four words, m_last on the fourth.
    cyc(0, 0, 1, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(1, i, 1);
      chk("basic_data", {16'b0, m_data}, i);
      chk("basic_last", {31'b0, m_last}, {31'b0, i == 4});
      repeat (3) cyc(0, 0, 1);
    end

    // Rounding, saturation and ReLU.
    sample = 5'd31;
    cyc(0, 0, 1, 1);
    shift = 5'd4;
    for (int i = 0; i < 5; i++) begin
      relu = (i == 4);
      cyc(1, rvals[i], 1);
      chk("round_data", {16'b0, m_data}, {16'b0, rexp[i]});
      cyc(0, 0, 1);
    end
    relu = 1'b0; shift = 5'd0;

    // Backpressure and overflow.
    cyc(0, 0, 0, 1);
    cyc(1, 10, 0);
    cyc(1, 20, 0);
    chk("bp_head", {16'b0, m_data}, 32'd10);
    cyc(1, 30, 0);
    chk("bp_ovf", {31'b0, ovf}, 32'd1);
    cyc(0, 0, 0);
    chk("bp_hold", {16'b0, m_data}, 32'd10);
    cyc(0, 0, 1);
    chk("bp_second", {16'b0, m_data}, 32'd20);
    cyc(0, 0, 1);
    chk("bp_drained", {31'b0, outrf}, 32'd1);
    cyc(0, 0, 1);

    // Simultaneous push and pop while full.
    cyc(0, 0, 0, 1);
    cyc(1, 40, 0);
    cyc(1, 50, 0);
    cyc(1, 60, 1);
    chk("sim_ovf", {31'b0, ovf}, 32'd0);
    repeat (4) cyc(0, 0, 1);

    // Wrap with sample=1, run restart after the fifth word.
    sample = 5'd1;
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 7; i++) begin
      cyc(1, 100 + i, 1);
      chk("wrap_last", {31'b0, m_last}, {31'b0, lexp[i]});
      cyc(0, 0, 1, i == 4);
    end

    // Reset mid-stream with the FIFO full and ovf set.
    sample = 5'd31;
    cyc(0, 0, 0, 1);
    cyc(1, 70, 0);
    cyc(1, 80, 0);
    cyc(1, 90, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_m_valid",  {31'b0, m_valid},  32'd0);
    chk("mid_rst_outrf",    {31'b0, outrf},    32'd1);
    chk("mid_rst_out_busy", {31'b0, out_busy}, 32'd0);
    chk("mid_rst_ovf",      {31'b0, ovf},      32'd0);
    q.delete(); npop = 0; ovf_m = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) cyc(0, 0, 1);

    // Random traffic.
    sample = 5'd6;
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 400; i++) begin
      shift = 5'($urandom_range(0, 31));
      relu  = 1'($urandom_range(0, 1));
      cyc($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 3) != 0);
    end
    repeat (4) cyc(0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/out_ctl.md
# out_ctl

Output-side controller sitting directly downstream of the execution controller in the ch07 convolution datapath. Each time a kernel dot-product finishes (`k_fin`), it captures the accumulator result, applies rounding shift, optional ReLU and saturation, buffers it in a 2-entry FIFO, and streams it out over a valid/ready handshake. It returns `out_busy` (blocks the next kernel start) and `outrf` (output path drained, gates sample finish) to the execution controller.

## Interface
Parameters:
- `ACCW`, 32, accumulator width (signed)
- `OW`, 16, output word width (signed)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `sample`  in  5  number of outputs per run minus 1 (same encoding as the execution controller's `sample`)
- `shift`  in  5  arithmetic right shift applied to the accumulator; 0 means no shift
- `relu`  in  1  1: clamp negative results to 0
- `s_init`  in  1  run start pulse
- `k_fin`  in  1  accumulator result valid this cycle (1-cycle pulse)
- `acc`  in  ACCW  accumulator value, sampled when `k_fin`=1
- `out_busy`  out  1  execution controller must not start a new kernel
- `outrf`  out  1  FIFO empty; no output pending
- `m_valid`  out  1  output word valid
- `m_ready`  in  1  downstream accepts word
- `m_data`  out  OW  output word
- `m_last`  out  1  marks the final word of the run
- `ovf`  out  1  sticky error: `k_fin` arrived with FIFO full

## Operation
- Conversion (combinational on `acc`, registered into FIFO): `r = shift==0 ? acc : (acc + (1 << (shift-1))) >>> shift`, computed at ACCW+1 bits (no wrap on the rounding add); if `relu` and `r<0` then `r=0`; saturate `r` to [-2^(OW-1), 2^(OW-1)-1].
- FIFO: 2 entries, write pointer, read pointer, 2-bit `count` (0..2).
  - Push on `k_fin` when `count<2`; push when `count==2` drops the word and sets `ovf`.
  - Pop on `m_valid & m_ready`.
  - Simultaneous push and pop: `count` unchanged, both pointers advance. With `count==2`, a pop in the same cycle as `k_fin` frees a slot, so the word is accepted and `ovf` is not set.
- `m_valid = (count != 0)`; `m_data` = head entry.
- `out_busy = (count >= 1)`. The execution controller runs at most one kernel in flight, so this guarantees a free slot at every `k_fin`.
- `outrf = (count == 0)`.
- Output counter `oc` (5 bits):
  - `m_last = m_valid & (oc == sample)`.
  - On each pop, `oc` increments, wrapping to 0 after `sample`.
- `s_init` clears `oc` and `ovf`. It does not flush the FIFO; the FIFO is empty at `s_init` by protocol, since a run starts only after the previous sample finish.
- `ovf` clears only on `rst` or `s_init`.

## Timing
- Reset values: `count=0`, pointers 0, `oc=0`, `ovf=0`. Outputs at reset: `m_valid=0`, `out_busy=0`, `outrf=1`, `m_last=0`, `m_data`=0 (FIFO storage reset to 0).
- `rst` mid-operation discards all buffered words immediately (asynchronous).
- Latency: `k_fin` in cycle t with FIFO empty gives `m_valid=1`, `out_busy=1` and `outrf=0` in cycle t+1.
- Handshake: while `m_valid & !m_ready`, `m_data` and `m_last` hold stable. `m_valid` never drops without a pop.
- `m_ready` high continuously: the word from cycle t is popped in t+1, and `out_busy` falls in t+2.
- Shift semantics:
  - `shift >= ACCW` is legal; the result is the rounded sign-extension (0 or -1 before ReLU).
  - `shift` and `relu` are sampled in the `k_fin` cycle only.

## Test plan
- Basic stream: `sample`=3, `shift`=0, `m_ready`=1, four `k_fin` with `acc`=1,2,3,4 spaced 4 cycles -> `m_data` 1,2,3,4; `m_last` only on 4. `outrf` returns to 1 one cycle after each pop.
- Rounding/saturation: OW=16, `shift`=4, `acc`=24 gives 2; `acc`=-24 gives -1; `acc`=0x7FFFFFFF gives 32767; `acc`=0x80000000 gives -32768. With `relu`=1, `acc`=-24 gives 0.
- Backpressure: `m_ready`=0, two `k_fin` -> `count`=2 and `m_data` holds the first word. A third `k_fin` sets `ovf`=1 and its word is lost. Raising `m_ready` drains the two words in order, then `outrf`=1.
- Simultaneous push/pop at full: `count`=2, `k_fin` with `m_ready`=1 in the same cycle -> `ovf` stays 0 and all three words come out in order.
- Wrap/run restart: `sample`=1, six outputs -> `m_last` on the 2nd, 4th and 6th words. `s_init` after the 5th clears `oc`, so `m_last` moves to the 7th word.
- Reset mid-stream: `rst` pulse with `count`=2 and `ovf`=1 -> immediately `m_valid`=0, `outrf`=1, `out_busy`=0, `ovf`=0. No stale word appears after reset release.
